// File: rtl/clk_ratio_monitor.sv
// Receiving-side monitor for a divided clock: measures each half-period of
// clock_slower in original_clock cycles and tracks lock, edges and errors.
module clk_ratio_monitor #(
    parameter int unsigned RATIO      = 5,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             original_clock,
    input  logic             reset_in,
    input  logic             clock_slower,
    input  logic             enable,
    input  logic             clear_errors,
    output logic             slow_rise,
    output logic             slow_fall,
    output logic [5:0]       phase_count,
    output logic             locked,
    output logic             error_pulse,
    output logic [ERR_W-1:0] error_count
);

    localparam int unsigned HP_W   = 6;
    localparam int unsigned GOOD_W = 4;

    localparam logic [HP_W-1:0] HP_GOOD    = HP_W'(RATIO - 1);
    localparam logic [HP_W-1:0] HP_TIMEOUT = HP_W'(2 * RATIO);
    localparam logic [HP_W-1:0] HP_MAX     = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [GOOD_W-1:0]   good;
    logic [GOOD_W-1:0]   good_nxt;
    logic                err_nxt;
    logic                s1;
    logic                s2;
    logic                s3;
    logic                edge_det;
    logic                hp_good;
    logic                timeout;
    logic                lock_reached;

    assign edge_det     = s2 != s3;
    assign hp_good      = phase_count == HP_GOOD;
    assign timeout      = !edge_det && (phase_count == HP_TIMEOUT);
    assign lock_reached = (5'(good) + 5'd1) == 5'(LOCK_COUNT);

    // Lock tracking; errors are only raised when falling out of LOCKED.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        err_nxt   = 1'b0;
        if (!enable) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (edge_det) begin
                        state_nxt = ACQUIRE;
                        good_nxt  = '0;
                    end
                end
                ACQUIRE: begin
                    if (edge_det) begin
                        if (hp_good) begin
                            good_nxt = good + GOOD_W'(1);
                            if (lock_reached) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            good_nxt = '0;
                        end
                    end else if (timeout) begin
                        state_nxt = SEARCH;
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        if (!hp_good) begin
                            state_nxt = ACQUIRE;
                            good_nxt  = '0;
                            err_nxt   = 1'b1;
                        end
                    end else if (timeout) begin
                        state_nxt = SEARCH;
                        err_nxt   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge original_clock or negedge reset_in) begin
        if (!reset_in) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    // Synchronizer keeps running regardless of enable.
    always_ff @(posedge original_clock or negedge reset_in) begin
        if (!reset_in) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clock_slower;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge original_clock or negedge reset_in) begin
        if (!reset_in) begin
            phase_count <= '0;
            slow_rise   <= 1'b0;
            slow_fall   <= 1'b0;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
        end else begin
            if (!enable || edge_det) begin
                phase_count <= '0;
            end else if (phase_count != HP_MAX) begin
                phase_count <= phase_count + HP_W'(1);
            end
            slow_rise   <= enable & s2 & ~s3;
            slow_fall   <= enable & ~s2 & s3;
            locked      <= state_nxt == LOCKED;
            error_pulse <= err_nxt;
        end
    end

    // Clear takes priority over a coincident error.
    always_ff @(posedge original_clock or negedge reset_in) begin
        if (!reset_in) begin
            error_count <= '0;
        end else if (clear_errors) begin
            error_count <= '0;
        end else if (err_nxt && (error_count != '1)) begin
            error_count <= error_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: directed sequences, a reset table and random
// half-periods, all checked cycle by cycle against a behavioural model.
module tb_clk_ratio_monitor;

    localparam int unsigned RATIO = 5;
    localparam int unsigned LC    = 4;

    logic       original_clock;
    logic       reset_in;
    logic       clock_slower;
    logic       enable;
    logic       clear_errors;
    logic       slow_rise;
    logic       slow_fall;
    logic [5:0] phase_count;
    logic       locked;
    logic       error_pulse;
    logic [7:0] error_count;
    logic       slow_rise2;
    logic       slow_fall2;
    logic [5:0] phase_count2;
    logic       locked2;
    logic       error_pulse2;
    logic [1:0] error_count2;

    clk_ratio_monitor #(.RATIO(RATIO), .LOCK_COUNT(LC), .ERR_W(8)) dut (
        .original_clock(original_clock), .reset_in(reset_in),
        .clock_slower(clock_slower), .enable(enable), .clear_errors(clear_errors),
        .slow_rise(slow_rise), .slow_fall(slow_fall), .phase_count(phase_count),
        .locked(locked), .error_pulse(error_pulse), .error_count(error_count)
    );

    clk_ratio_monitor #(.RATIO(RATIO), .LOCK_COUNT(LC), .ERR_W(2)) dut2 (
        .original_clock(original_clock), .reset_in(reset_in),
        .clock_slower(clock_slower), .enable(enable), .clear_errors(clear_errors),
        .slow_rise(slow_rise2), .slow_fall(slow_fall2), .phase_count(phase_count2),
        .locked(locked2), .error_pulse(error_pulse2), .error_count(error_count2)
    );

    initial original_clock = 1'b0;
    always #5 original_clock = ~original_clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: sample history, time since last edge, lock mode.
    localparam int M_SEARCH = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCK   = 2;

    bit samp_q[$];
    int m_since;
    int m_mode;
    int m_streak;
    int m_cnt;
    int m_cnt2;
    bit e_rise, e_fall, e_lock, e_err;

    task automatic model_reset();
        samp_q   = '{1'b0, 1'b0, 1'b0};
        m_since  = 0;
        m_mode   = M_SEARCH;
        m_streak = 0;
        m_cnt    = 0;
        m_cnt2   = 0;
        e_rise   = 0;
        e_fall   = 0;
        e_lock   = 0;
        e_err    = 0;
    endtask

    task automatic model_update(input bit cs, input bit en, input bit clr);
        bit s2, s3, ed, err, ok;
        s2  = samp_q[1];
        s3  = samp_q[2];
        ed  = s2 != s3;
        err = 0;
        if (!en) begin
            m_mode   = M_SEARCH;
            m_streak = 0;
            m_since  = 0;
            e_rise   = 0;
            e_fall   = 0;
        end else begin
            e_rise = s2 && !s3;
            e_fall = !s2 && s3;
            if (ed) begin
                ok = (m_since == int'(RATIO) - 1);
                if (m_mode == M_SEARCH) begin
                    m_mode   = M_ACQ;
                    m_streak = 0;
                end else if (m_mode == M_ACQ) begin
                    if (ok) begin
                        m_streak++;
                        if (m_streak == int'(LC)) m_mode = M_LOCK;
                    end else begin
                        m_streak = 0;
                    end
                end else if (!ok) begin
                    m_mode   = M_ACQ;
                    m_streak = 0;
                    err      = 1;
                end
                m_since = 0;
            end else begin
                if (m_since == 2 * int'(RATIO) && m_mode != M_SEARCH) begin
                    if (m_mode == M_LOCK) err = 1;
                    m_mode = M_SEARCH;
                end
                m_since++;
            end
        end
        e_lock = en && (m_mode == M_LOCK);
        e_err  = err;
        if (clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (err) begin
            m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
            m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        end
        samp_q.push_front(cs);
        void'(samp_q.pop_back());
    endtask

    task automatic compare_model();
        chk("rise",     32'(slow_rise),    32'(e_rise));
        chk("fall",     32'(slow_fall),    32'(e_fall));
        chk("phase",    32'(phase_count),  (m_since > 63) ? 32'd63 : 32'(m_since));
        chk("locked",   32'(locked),       32'(e_lock));
        chk("err_pulse",32'(error_pulse),  32'(e_err));
        chk("err_count",32'(error_count),  32'(m_cnt));
        chk("err_count_w2", 32'(error_count2), 32'(m_cnt2));
        chk("locked_w2",32'(locked2),      32'(e_lock));
    endtask

    int cyc = 0;
    int first_strobe;
    int lock_at;
    int errp;

    task automatic arm();
        first_strobe = -1;
        lock_at      = -1;
        errp         = 0;
    endtask

    task automatic step();
        @(posedge original_clock);
        model_update(clock_slower, enable, clear_errors);
        @(negedge original_clock);
        compare_model();
        cyc++;
        if (first_strobe < 0 && (slow_rise || slow_fall)) first_strobe = cyc;
        if (lock_at < 0 && locked) lock_at = cyc;
        if (error_pulse) errp++;
    endtask

    task automatic half(input int n);
        clock_slower = ~clock_slower;
        repeat (n) step();
    endtask

    typedef struct {
        bit       cs;
        bit       en;
        bit       clr;
        bit       rise;
        bit       fall;
        int       phase;
        bit       lock;
        bit       err;
    } vec_t;

    vec_t tbl[4];
    logic [7:0] held;

    initial begin
        tbl[0] = '{cs: 1, en: 1, clr: 0, rise: 0, fall: 0, phase: 1, lock: 0, err: 0};
        tbl[1] = '{cs: 1, en: 1, clr: 0, rise: 0, fall: 0, phase: 2, lock: 0, err: 0};
        tbl[2] = '{cs: 1, en: 1, clr: 0, rise: 1, fall: 0, phase: 0, lock: 0, err: 0};
        tbl[3] = '{cs: 1, en: 1, clr: 0, rise: 0, fall: 0, phase: 1, lock: 0, err: 0};

        reset_in     = 1'b0;
        clock_slower = 1'b0;
        enable       = 1'b1;
        clear_errors = 1'b0;
        model_reset();
        arm();
        #12;
        compare_model();
        @(negedge original_clock);
        reset_in = 1'b1;

        // Ideal input locks LOCK_COUNT*RATIO cycles after the first strobe.
        arm();
        repeat (10) half(5);
        chk("lock_delay", 32'(lock_at - first_strobe), 32'(LC * RATIO));
        chk("lock_ideal", 32'(locked), 32'd1);
        chk("no_errors", 32'(error_count), 32'd0);

        // One short half-period while locked.
        arm();
        half(4);
        repeat (6) half(5);
        chk("short_errp", 32'(errp), 32'd1);
        chk("short_cnt", 32'(error_count), 32'd1);
        chk("short_relock", 32'(locked), 32'd1);

        // Stuck input: timeout then phase saturates.
        arm();
        repeat (70) step();
        chk("stuck_errp", 32'(errp), 32'd1);
        chk("stuck_locked", 32'(locked), 32'd0);
        chk("stuck_phase", 32'(phase_count), 32'd63);

        repeat (10) half(5);
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;

        // Five errors saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            half(3);
            repeat (5) half(5);
        end
        chk("sat_cnt_w2", 32'(error_count2), 32'd3);
        chk("sat_cnt_w8", 32'(error_count), 32'd5);

        // Clear coinciding with an error: clear wins, pulse still fires.
        half(3);
        clock_slower = ~clock_slower;
        repeat (2) step();
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        chk("clr_pulse", 32'(error_pulse), 32'd1);
        chk("clr_cnt", 32'(error_count), 32'd0);
        chk("clr_cnt_w2", 32'(error_count2), 32'd0);
        repeat (6) half(5);

        // Enable low while locked.
        chk("pre_dis_locked", 32'(locked), 32'd1);
        held = error_count;
        half(3);
        repeat (2) half(5);
        held = error_count;
        enable = 1'b0;
        step();
        chk("dis_locked", 32'(locked), 32'd0);
        chk("dis_phase", 32'(phase_count), 32'd0);
        chk("dis_hold", 32'(error_count), 32'(held));
        repeat (4) step();
        repeat (2) half(5);
        chk("dis_strobes", 32'(slow_rise | slow_fall), 32'd0);
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        chk("dis_clear", 32'(error_count), 32'd0);
        repeat (4) step();
        enable = 1'b1;
        arm();
        repeat (10) half(5);
        chk("reen_delay", 32'(lock_at - first_strobe), 32'(LC * RATIO));
        chk("reen_locked", 32'(locked), 32'd1);

        // Asynchronous reset between clock edges.
        half(3);
        repeat (6) half(5);
        @(posedge original_clock);
        #2;
        reset_in = 1'b0;
        #1;
        chk("ar_rise", 32'(slow_rise), 32'd0);
        chk("ar_fall", 32'(slow_fall), 32'd0);
        chk("ar_phase", 32'(phase_count), 32'd0);
        chk("ar_locked", 32'(locked), 32'd0);
        chk("ar_errp", 32'(error_pulse), 32'd0);
        chk("ar_cnt", 32'(error_count), 32'd0);
        chk("ar_cnt_w2", 32'(error_count2), 32'd0);
        model_reset();
        clock_slower = 1'b1;
        @(negedge original_clock);
        reset_in = 1'b1;

        for (int i = 0; i < 4; i++) begin
            clock_slower = tbl[i].cs;
            enable       = tbl[i].en;
            clear_errors = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_rise", i),   32'(slow_rise),   32'(tbl[i].rise));
            chk($sformatf("tbl%0d_fall", i),   32'(slow_fall),   32'(tbl[i].fall));
            chk($sformatf("tbl%0d_phase", i),  32'(phase_count), 32'(tbl[i].phase));
            chk($sformatf("tbl%0d_locked", i), 32'(locked),      32'(tbl[i].lock));
            chk($sformatf("tbl%0d_err", i),    32'(error_pulse), 32'(tbl[i].err));
        end

        // Randomized half-periods, enable drops and clears.
        for (int h = 0; h < 120; h++) begin
            int len;
            len = ($urandom_range(0, 9) < 7) ? int'(RATIO) : int'($urandom_range(2, 13));
            clock_slower = ~clock_slower;
            for (int c = 0; c < len; c++) begin
                enable       = ($urandom_range(0, 59) != 0);
                clear_errors = ($urandom_range(0, 49) == 0);
                step();
            end
        end
        enable       = 1'b1;
        clear_errors = 1'b0;
        repeat (8) half(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_ratio_monitor.md
# clk_ratio_monitor

Checks the divided clock produced by the design's clock generator from the receiving side. It runs on `original_clock` and samples `clock_slower` as a plain data signal. Each half-period is measured in `original_clock` cycles and compared against `RATIO`. The block reports lock, single-cycle edge strobes for downstream logic, and a saturating error count. It sits beside the clock generator in the 2-stage synthesis top as a ratio and health monitor.

## Interface
- `RATIO`, 5: expected `clock_slower` half-period in `original_clock` cycles; legal range 1..31.
- `LOCK_COUNT`, 4: consecutive good half-periods required to declare lock; legal range 1..15.
- `ERR_W`, 8: width of the error counter.
- `original_clock` in 1: single clock for all state.
- `reset_in` in 1: asynchronous, active-low reset.
- `clock_slower` in 1: monitored divided clock, treated as asynchronous data.
- `enable` in 1: monitoring enable; low forces idle.
- `clear_errors` in 1: synchronous clear of `error_count`.
- `slow_rise` out 1: one-cycle strobe per detected rising edge.
- `slow_fall` out 1: one-cycle strobe per detected falling edge.
- `phase_count` out 6: cycles elapsed since the last detected edge.
- `locked` out 1: high while the FSM is in LOCKED.
- `error_pulse` out 1: one-cycle strobe per error.
- `error_count` out ERR_W: saturating error total.

## Operation
- **Input pipeline:**
  - `s1 <= clock_slower; s2 <= s1; s3 <= s2`; `s1`/`s2` form the synchronizer.
  - Edge = `s2 != s3`.
  - Outputs are registered: `slow_rise <= en & s2 & ~s3`, `slow_fall <= en & ~s2 & s3`.
- **Half-period counter `hp` (6 bits, drives `phase_count`):**
  - Loads 0 on a detected edge.
  - Otherwise increments, saturating at 63.
  - A good half-period means an edge is detected while `hp == RATIO-1`.
- **Timeout:** no edge detected while `hp == 2*RATIO`.
- **FSM states:** SEARCH (reset state), ACQUIRE, LOCKED. Counter `good` is 4 bits.
  - SEARCH: the first edge moves to ACQUIRE with `good=0`. No check is made on this edge, because the preceding interval is unknown.
  - ACQUIRE, edge:
    - Good: `good++`. When `good+1 == LOCK_COUNT`, go to LOCKED.
    - Bad: `good=0`, stay in ACQUIRE.
  - ACQUIRE, timeout: go to SEARCH. This is not an error.
  - LOCKED, good edge: stay.
  - LOCKED, bad edge: go to ACQUIRE with `good=0` and raise an error.
  - LOCKED, timeout: go to SEARCH and raise an error.
  - Errors are raised only from LOCKED.
- **Error handling:**
  - On error, `error_pulse` is high for the next cycle and `error_count++`, saturating at all-ones.
  - `clear_errors` in the same cycle as an error: clear wins, and `error_count` becomes 0. `error_pulse` still fires.
- **`enable` low:**
  - FSM goes to SEARCH and `hp` goes to 0.
  - `slow_rise`, `slow_fall`, `error_pulse`, `locked` go to 0.
  - `error_count` holds, and `clear_errors` still works.
  - The synchronizer keeps running.
- `locked` is registered from the next-state value, so it rises in the same cycle the FSM state becomes LOCKED.

## Timing
- **Reset values:** all outputs 0; `s1..s3` = 0; `hp` = 0; `good` = 0; state = SEARCH.
- **Edge latency:** a `clock_slower` change sampled at edge N appears as a `slow_rise`/`slow_fall` pulse after edge N+2. `hp` reloads at the same edge.
- **Error latency:** `error_pulse` follows the detecting edge by one cycle. `error_count` updates on the same edge as `error_pulse`.
- **Lock time:** from the first detected edge, a clean `clock_slower` reaches `locked=1` `LOCK_COUNT` half-periods later, i.e. `LOCK_COUNT*RATIO` cycles.
- **Reset mid-operation:** immediate return to reset values, independent of the clock.
- **Reset release at power-up:** `s1..s3` reset to 0, so a `clock_slower` that is high at release yields a `slow_rise` 3 cycles later. That edge is consumed by SEARCH and counts as neither good nor error.

## Test plan
- **Lock, ideal input:** `clock_slower` toggling every 5 cycles, `RATIO=5`, `LOCK_COUNT=4` -> `locked` rises 20 cycles after the first strobe; strobes alternate rise/fall every 5 cycles; `error_count` stays 0.
- **Short half-period while locked:** one half-period of 4 cycles -> one `error_pulse`, `error_count=1`, `locked` drops and returns after 4 more good half-periods.
- **Stuck input while locked:** hold `clock_slower` constant -> timeout at `hp==10`, `error_pulse`, state SEARCH, `locked=0`, `phase_count` reads 10 then counts up and saturates at 63.
- **Saturation and clear:** with `ERR_W=2`, inject 5 errors -> `error_count=3`. Assert `clear_errors` in the same cycle as an error -> `error_count=0` and `error_pulse=1`.
- **`enable` low while locked:**
  - Expected: `locked`, strobes and `hp` go to 0 the next cycle; `error_count` holds.
  - On re-enable, lock is re-acquired after 1 unchecked edge plus 4 good half-periods.
- **Async reset while locked:** assert `reset_in=0` between clock edges -> all outputs 0 immediately. After release with `clock_slower` high, the first `slow_rise` appears at edge 3 with no error.
